// File: rtl/alarm_if.sv
// Sensor, control and status bundle of the alarm controller.
// The bench drives it through master; the controller uses the slave view.
interface alarm_if #(
  parameter int unsigned N_SENSORS = 4
);
  logic [N_SENSORS-1:0] sensor_i;
  logic [N_SENSORS-1:0] zone_mask_i;
  logic                 arm_i;
  logic                 ack_i;
  logic                 armed_o;
  logic                 alarm_o;
  logic                 siren_o;
  logic [1:0]           state_o;
  logic [N_SENSORS-1:0] trip_zones_o;

  modport master (
    output sensor_i, zone_mask_i, arm_i, ack_i,
    input  armed_o, alarm_o, siren_o, state_o, trip_zones_o
  );

  modport slave (
    input  sensor_i, zone_mask_i, arm_i, ack_i,
    output armed_o, alarm_o, siren_o, state_o, trip_zones_o
  );
endinterface

// File: rtl/alarm_controller.sv
// Multi-zone intrusion alarm: per-channel sync + debounce, masked vote,
// armed/entry-delay/alarm state machine with a timed siren.
module alarm_controller #(
  parameter int unsigned N_SENSORS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ENTRY_DELAY     = 16,
  parameter int unsigned SIREN_CYCLES    = 64,
  parameter int unsigned VOTE_MIN        = 1
) (
  input logic   clk,
  input logic   rst_n,
  alarm_if.slave bus
);
  localparam int unsigned CW = $clog2(N_SENSORS + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned EW = (ENTRY_DELAY > 1) ? $clog2(ENTRY_DELAY) : 1;
  localparam int unsigned SW = (SIREN_CYCLES > 1) ? $clog2(SIREN_CYCLES) : 1;

  localparam logic [1:0] StDisarmed = 2'd0;
  localparam logic [1:0] StArmed    = 2'd1;
  localparam logic [1:0] StEntry    = 2'd2;
  localparam logic [1:0] StAlarm    = 2'd3;

  logic [N_SENSORS-1:0] sync1_q, sync2_q, db_q, db_d, hit;
  logic [DW-1:0]        deb_cnt_q [N_SENSORS];
  logic [DW-1:0]        deb_cnt_d [N_SENSORS];
  logic [CW-1:0]        hit_cnt;
  logic                 trip;

  logic [1:0]           state_q, state_d;
  logic [EW-1:0]        entry_q, entry_d;
  logic [SW-1:0]        siren_cnt_q, siren_cnt_d;
  logic                 siren_q, siren_d;
  logic [N_SENSORS-1:0] zones_q, zones_d;
  logic                 go_disarm;

  // db only flips after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_comb begin
    for (int unsigned i = 0; i < N_SENSORS; i++) begin
      db_d[i]      = db_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = ~db_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    hit     = db_q & bus.zone_mask_i;
    hit_cnt = '0;
    for (int unsigned i = 0; i < N_SENSORS; i++) begin
      hit_cnt = hit_cnt + CW'(hit[i]);
    end
    trip = (hit_cnt >= CW'(VOTE_MIN));
  end

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    siren_cnt_d = siren_cnt_q;
    siren_d     = siren_q;
    zones_d     = zones_q;
    go_disarm   = 1'b0;
    case (state_q)
      StDisarmed: begin
        if (bus.arm_i) state_d = StArmed;
      end
      StArmed: begin
        if (!bus.arm_i) begin
          go_disarm = 1'b1;
        end else if (trip) begin
          state_d = StEntry;
          entry_d = EW'(ENTRY_DELAY - 1);
          zones_d = zones_q | hit;
        end
      end
      StEntry: begin
        if (!bus.arm_i) begin
          go_disarm = 1'b1;
        end else begin
          zones_d = zones_q | hit;
          if (entry_q == '0) begin
            state_d     = StAlarm;
            siren_cnt_d = SW'(SIREN_CYCLES - 1);
            siren_d     = 1'b1;
          end else begin
            entry_d = entry_q - 1'b1;
          end
        end
      end
      StAlarm: begin
        if (bus.ack_i) begin
          siren_d     = 1'b0;
          siren_cnt_d = '0;
          go_disarm   = !bus.arm_i;
        end else if (siren_cnt_q == '0) begin
          siren_d = 1'b0;
        end else begin
          siren_cnt_d = siren_cnt_q - 1'b1;
        end
      end
      default: state_d = StDisarmed;
    endcase
    if (go_disarm) begin
      state_d     = StDisarmed;
      entry_d     = '0;
      siren_cnt_d = '0;
      siren_d     = 1'b0;
      zones_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      for (int unsigned i = 0; i < N_SENSORS; i++) deb_cnt_q[i] <= '0;
      state_q     <= StDisarmed;
      entry_q     <= '0;
      siren_cnt_q <= '0;
      siren_q     <= 1'b0;
      zones_q     <= '0;
    end else begin
      sync1_q     <= bus.sensor_i;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      for (int unsigned i = 0; i < N_SENSORS; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      state_q     <= state_d;
      entry_q     <= entry_d;
      siren_cnt_q <= siren_cnt_d;
      siren_q     <= siren_d;
      zones_q     <= zones_d;
    end
  end

  assign bus.state_o      = state_q;
  assign bus.armed_o      = (state_q != StDisarmed);
  assign bus.alarm_o      = (state_q == StAlarm);
  assign bus.siren_o      = siren_q;
  assign bus.trip_zones_o = zones_q;
endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench: default-parameter controller plus a VOTE_MIN=2 instance
// for the vote/mask scenario.
module tb_alarm_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alarm_if #(.N_SENSORS(4)) bus_a ();
  alarm_if #(.N_SENSORS(4)) bus_b ();

  alarm_controller #(
    .N_SENSORS(4), .DEBOUNCE_CYCLES(4), .ENTRY_DELAY(16), .SIREN_CYCLES(64), .VOTE_MIN(1)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  alarm_controller #(
    .N_SENSORS(4), .DEBOUNCE_CYCLES(4), .ENTRY_DELAY(16), .SIREN_CYCLES(64), .VOTE_MIN(2)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1ns later.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Arm dut_a, raise one sensor, and land in ALARM (edge 23 after the rise).
  task automatic reach_alarm(input int zone);
    bus_a.arm_i = 1'b1;
    tick(1);
    bus_a.sensor_i[zone] = 1'b1;
    tick(7);
    check_eq("alarm_path_entry", 32'(bus_a.state_o), 32'd2);
    bus_a.sensor_i = '0;
    tick(16);
    check_eq("alarm_path_alarm", 32'(bus_a.state_o), 32'd3);
  endtask

  logic alarm_seen;

  initial begin
    rst_n             = 1'b0;
    bus_a.sensor_i    = '0;
    bus_a.zone_mask_i = 4'hf;
    bus_a.arm_i       = 1'b0;
    bus_a.ack_i       = 1'b0;
    bus_b.sensor_i    = '0;
    bus_b.zone_mask_i = 4'b0111;
    bus_b.arm_i       = 1'b0;
    bus_b.ack_i       = 1'b0;
    tick(2);
    check_eq("rst_state", 32'(bus_a.state_o), 32'd0);
    check_eq("rst_outs", {bus_a.armed_o, bus_a.alarm_o, bus_a.siren_o, bus_a.trip_zones_o},
             32'd0);
    rst_n = 1'b1;
    tick(2);
    check_eq("idle_state", 32'(bus_a.state_o), 32'd0);

    // Debounce: a 3-cycle pulse is rejected, a held level trips on edge 7.
    bus_a.arm_i = 1'b1;
    tick(1);
    check_eq("armed_state", 32'(bus_a.state_o), 32'd1);
    check_eq("armed_flag", 32'(bus_a.armed_o), 32'd1);
    bus_a.sensor_i[0] = 1'b1;
    tick(3);
    bus_a.sensor_i[0] = 1'b0;
    tick(10);
    check_eq("glitch_rejected", 32'(bus_a.state_o), 32'd1);
    bus_a.sensor_i[0] = 1'b1;
    tick(6);
    check_eq("deb_edge6", 32'(bus_a.state_o), 32'd1);
    tick(1);
    check_eq("deb_edge7", 32'(bus_a.state_o), 32'd2);
    check_eq("deb_zones", 32'(bus_a.trip_zones_o), 32'h1);
    bus_a.sensor_i = '0;
    bus_a.arm_i    = 1'b0;
    tick(1);
    check_eq("deb_disarm", 32'(bus_a.state_o), 32'd0);
    tick(10);

    // Disarm in time after 10 ENTRY cycles.
    alarm_seen  = 1'b0;
    bus_a.arm_i = 1'b1;
    tick(1);
    bus_a.sensor_i[2] = 1'b1;
    tick(7);
    check_eq("dit_entry", 32'(bus_a.state_o), 32'd2);
    bus_a.sensor_i = '0;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      alarm_seen |= bus_a.alarm_o;
    end
    check_eq("dit_zones", 32'(bus_a.trip_zones_o), 32'h4);
    bus_a.arm_i = 1'b0;
    tick(1);
    alarm_seen |= bus_a.alarm_o;
    check_eq("dit_state", 32'(bus_a.state_o), 32'd0);
    check_eq("dit_zclr", 32'(bus_a.trip_zones_o), 32'h0);
    check_eq("dit_no_alarm", 32'(alarm_seen), 32'd0);
    tick(10);

    // Full alarm: exact entry length and 64-cycle siren.
    bus_a.arm_i = 1'b1;
    tick(1);
    bus_a.sensor_i[1] = 1'b1;
    tick(7);
    check_eq("full_entry", 32'(bus_a.state_o), 32'd2);
    bus_a.sensor_i = '0;
    tick(15);
    check_eq("full_entry_last", 32'(bus_a.state_o), 32'd2);
    check_eq("full_no_alarm_yet", 32'(bus_a.alarm_o), 32'd0);
    tick(1);
    check_eq("full_alarm", {bus_a.state_o, bus_a.alarm_o, bus_a.siren_o}, 32'hf);
    tick(63);
    check_eq("siren_last", 32'(bus_a.siren_o), 32'd1);
    tick(1);
    check_eq("siren_off", 32'(bus_a.siren_o), 32'd0);
    check_eq("alarm_latched", 32'(bus_a.alarm_o), 32'd1);
    check_eq("full_zones", 32'(bus_a.trip_zones_o), 32'h2);
    bus_a.arm_i = 1'b0;
    tick(1);
    check_eq("arm0_stays_alarm", 32'(bus_a.state_o), 32'd3);
    bus_a.ack_i = 1'b1;
    tick(1);
    check_eq("full_ack_clear", 32'(bus_a.state_o), 32'd0);
    bus_a.ack_i = 1'b0;
    tick(10);

    // Ack silences the siren without leaving ALARM, then ack+disarm clears.
    reach_alarm(3);
    tick(5);
    check_eq("ack_siren_pre", 32'(bus_a.siren_o), 32'd1);
    bus_a.ack_i = 1'b1;
    tick(1);
    check_eq("ack_siren", 32'(bus_a.siren_o), 32'd0);
    check_eq("ack_state", 32'(bus_a.state_o), 32'd3);
    bus_a.ack_i = 1'b0;
    tick(3);
    check_eq("ack_siren_stays", 32'(bus_a.siren_o), 32'd0);
    bus_a.arm_i = 1'b0;
    bus_a.ack_i = 1'b1;
    tick(1);
    check_eq("ack_disarm", 32'(bus_a.state_o), 32'd0);
    check_eq("ack_disarm_outs", {bus_a.armed_o, bus_a.alarm_o, bus_a.siren_o,
             bus_a.trip_zones_o}, 32'd0);
    bus_a.ack_i = 1'b0;
    tick(10);

    // Sensor already active while disarmed: arming goes to ARMED first.
    bus_a.sensor_i[0] = 1'b1;
    tick(8);
    bus_a.arm_i = 1'b1;
    tick(1);
    check_eq("arm_trip_armed", 32'(bus_a.state_o), 32'd1);
    tick(1);
    check_eq("arm_trip_entry", 32'(bus_a.state_o), 32'd2);
    bus_a.arm_i    = 1'b0;
    bus_a.sensor_i = '0;
    tick(10);

    // Asynchronous reset in the middle of ALARM with the siren on.
    reach_alarm(0);
    check_eq("rst_pre_siren", 32'(bus_a.siren_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_outs", {bus_a.state_o, bus_a.armed_o, bus_a.alarm_o, bus_a.siren_o,
             bus_a.trip_zones_o}, 32'd0);
    bus_a.arm_i = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check_eq("rst_release_state", 32'(bus_a.state_o), 32'd0);

    // Vote/mask on the VOTE_MIN=2 instance.
    bus_b.arm_i = 1'b1;
    tick(1);
    check_eq("vote_armed", 32'(bus_b.state_o), 32'd1);
    bus_b.sensor_i = 4'b1000;
    tick(10);
    check_eq("vote_s3_only", 32'(bus_b.state_o), 32'd1);
    bus_b.sensor_i = 4'b1001;
    tick(10);
    check_eq("vote_s0_s3", 32'(bus_b.state_o), 32'd1);
    bus_b.sensor_i = 4'b0011;
    tick(6);
    check_eq("vote_pre", 32'(bus_b.state_o), 32'd1);
    tick(1);
    check_eq("vote_entry", 32'(bus_b.state_o), 32'd2);
    check_eq("vote_zones", 32'(bus_b.trip_zones_o), 32'h3);
    bus_b.zone_mask_i = 4'b0000;
    tick(3);
    check_eq("mask_mid_entry", 32'(bus_b.state_o), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
